// File: rtl/lc3b_types.sv
// Shared LC-3b types: opcode encoding, memory-stage FSM states and the
// opcode classifiers the memory stage uses to pick an access sequence.
package lc3b_types;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] lc3b_word;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PTR    = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } mem_stage_state;

    function automatic logic is_mem_read(input lc3b_opcode op);
        return (op == op_ldr) || (op == op_ldb) || (op == op_ldi);
    endfunction

    function automatic logic is_mem_write(input lc3b_opcode op);
        return (op == op_str) || (op == op_stb) || (op == op_sti);
    endfunction

    function automatic logic is_byte_op(input lc3b_opcode op);
        return (op == op_ldb) || (op == op_stb);
    endfunction

    // LDI/STI first fetch a pointer word, then access through it.
    function automatic logic is_indirect(input lc3b_opcode op);
        return (op == op_ldi) || (op == op_sti);
    endfunction

endpackage

// File: rtl/mem_byte_format.sv
// Byte-lane formatting for the memory stage: load byte select with sign
// extension, store byte replication and byte-enable generation.
module mem_byte_format #(
    parameter int ADDR_W = 16
) (
    input  logic              byte_op,
    input  logic              addr_lsb,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [ADDR_W-1:0] rdata,
    output logic [ADDR_W-1:0] store_data,
    output logic [1:0]        byte_enable,
    output logic [ADDR_W-1:0] load_value
);

    logic [7:0] sel_byte;

    always_comb begin
        sel_byte    = addr_lsb ? rdata[15:8] : rdata[7:0];
        store_data  = wdata;
        byte_enable = 2'b11;
        load_value  = rdata;
        if (byte_op) begin
            // The memory picks the lane from the enables, so the byte goes on both.
            store_data  = {(ADDR_W/8){wdata[7:0]}};
            byte_enable = addr_lsb ? 2'b10 : 2'b01;
            load_value  = {{(ADDR_W-8){sel_byte[7]}}, sel_byte};
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// LC-3b memory-stage sequencer: runs word, byte and indirect accesses
// against the single-ported data memory and stalls the pipeline meanwhile.
module mem_stage_ctrl
    import lc3b_types::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  lc3b_opcode        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] wdata,
    output logic              stall,
    output logic              done,
    output logic [ADDR_W-1:0] load_data,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [ADDR_W-1:0] dmem_wdata,
    output logic [1:0]        dmem_byte_enable,
    input  logic [ADDR_W-1:0] dmem_rdata,
    input  logic              dmem_resp,
    output mem_stage_state    dbg_state
);

    // Handshake: a memory op presented with req_valid is taken in IDLE and
    // held upstream by stall until the DONE cycle, when stall drops and the
    // pipeline advances; the op still in the latch during DONE is not retaken.
    // Memory side: read/write strobes stay up with a stable address until the
    // single-cycle dmem_resp; dmem_resp outside PTR/ACCESS is ignored.

    mem_stage_state    state_q, state_d;
    lc3b_opcode        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] wdata_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] load_data_q;

    logic              is_mem_op;
    logic              accept;
    logic              op_is_byte;
    logic [ADDR_W-1:0] access_addr;
    logic [ADDR_W-1:0] fmt_store;
    logic [1:0]        fmt_be;
    logic [ADDR_W-1:0] fmt_load;

    assign is_mem_op   = is_mem_read(opcode) || is_mem_write(opcode);
    assign op_is_byte  = is_byte_op(op_q);
    assign access_addr = is_indirect(op_q) ? ptr_q : addr_q;

    mem_byte_format #(
        .ADDR_W(ADDR_W)
    ) u_fmt (
        .byte_op    (op_is_byte),
        .addr_lsb   (access_addr[0]),
        .wdata      (wdata_q),
        .rdata      (dmem_rdata),
        .store_data (fmt_store),
        .byte_enable(fmt_be),
        .load_value (fmt_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= op_br;
            addr_q      <= '0;
            wdata_q     <= '0;
            ptr_q       <= '0;
            load_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= opcode;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state_q == PTR && dmem_resp) begin
                ptr_q <= dmem_rdata;
            end
            // Stores leave the previous load result in place.
            if (state_q == ACCESS && dmem_resp && is_mem_read(op_q)) begin
                load_data_q <= fmt_load;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        accept           = 1'b0;
        done             = 1'b0;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = '0;
        dmem_wdata       = '0;
        dmem_byte_enable = 2'b00;
        case (state_q)
            IDLE: begin
                if (req_valid && is_mem_op) begin
                    accept  = 1'b1;
                    state_d = is_indirect(opcode) ? PTR : ACCESS;
                end
            end
            PTR: begin
                dmem_read        = 1'b1;
                dmem_address     = {addr_q[ADDR_W-1:1], 1'b0};
                dmem_byte_enable = 2'b11;
                if (dmem_resp) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                dmem_read        = is_mem_read(op_q);
                dmem_write       = is_mem_write(op_q);
                dmem_address     = op_is_byte ? access_addr
                                              : {access_addr[ADDR_W-1:1], 1'b0};
                dmem_wdata       = fmt_store;
                dmem_byte_enable = fmt_be;
                if (dmem_resp) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stall     = (state_q != DONE) && req_valid && is_mem_op;
    assign load_data = load_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed cases, non-memory ops, mid-op reset and
// randomized back-to-back traffic against a behavioural access model.
module tb_mem_stage_ctrl;
    import lc3b_types::*;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    lc3b_opcode     opcode;
    logic [15:0]    addr;
    logic [15:0]    wdata;
    logic           stall;
    logic           done;
    logic [15:0]    load_data;
    logic           dmem_read;
    logic           dmem_write;
    logic [15:0]    dmem_address;
    logic [15:0]    dmem_wdata;
    logic [1:0]     dmem_byte_enable;
    logic [15:0]    dmem_rdata;
    logic           dmem_resp;
    mem_stage_state dbg_state;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.ADDR_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .opcode          (opcode),
        .addr            (addr),
        .wdata           (wdata),
        .stall           (stall),
        .done            (done),
        .load_data       (load_data),
        .dmem_read       (dmem_read),
        .dmem_write      (dmem_write),
        .dmem_address    (dmem_address),
        .dmem_wdata      (dmem_wdata),
        .dmem_byte_enable(dmem_byte_enable),
        .dmem_rdata      (dmem_rdata),
        .dmem_resp       (dmem_resp),
        .dbg_state       (dbg_state)
    );

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_load;

    typedef struct {
        int              n_phase;
        logic [1:0][15:0] addr;
        logic [1:0][1:0]  be;
        logic [1:0]       rd;
        logic [1:0]       wr;
        logic [1:0][15:0] wd;
        int              done_cyc;
        logic [15:0]     load;
        logic [5:0]      proto_err;
    } obs_t;

    typedef struct {
        lc3b_opcode  op;
        logic [15:0] a, wd, rd0, rd1;
        int          l0, l1, nph;
        logic [15:0] ptr_addr, acc_addr;
        logic [1:0]  be;
        logic        wr;
        logic [15:0] wdat, load;
        int          done_cyc;
    } dir_t;

    function automatic bit tb_is_load(input lc3b_opcode op);
        return op == op_ldr || op == op_ldb || op == op_ldi;
    endfunction

    function automatic bit tb_is_mem(input lc3b_opcode op);
        return tb_is_load(op) || op == op_str || op == op_stb || op == op_sti;
    endfunction

    // Expected bus activity and result of one memory op, from the access rules.
    function automatic obs_t model_op(input lc3b_opcode op, input logic [15:0] a, wd, rd0, rd1,
                                      input int l0, l1, input logic [15:0] prev);
        obs_t e;
        bit   ind, byt, ld;
        int   ai, ti, di, b, fp;
        ind = (op == op_ldi || op == op_sti);
        byt = (op == op_ldb || op == op_stb);
        ld  = tb_is_load(op);
        ai  = int'(a);
        e.addr = '0; e.be = '0; e.rd = '0; e.wr = '0; e.wd = '0; e.proto_err = '0;
        if (ind) begin
            e.n_phase  = 2;
            e.addr[0]  = 16'(ai - ai % 2);
            e.be[0]    = 2'b11;
            e.rd[0]    = 1'b1;
            ti         = int'(rd0);
            di         = int'(rd1);
            e.done_cyc = l0 + l1 + 1;
        end else begin
            e.n_phase  = 1;
            ti         = ai;
            di         = int'(rd0);
            e.done_cyc = l0 + 1;
        end
        fp = e.n_phase - 1;
        e.addr[fp] = byt ? 16'(ti) : 16'(ti - ti % 2);
        e.be[fp]   = byt ? ((ti % 2 == 1) ? 2'b10 : 2'b01) : 2'b11;
        e.rd[fp]   = ld;
        e.wr[fp]   = !ld;
        e.wd[fp]   = byt ? 16'((int'(wd) % 256) * 257) : wd;
        if (!ld) begin
            e.load = prev;
        end else if (byt) begin
            b      = (di >> (8 * (ti % 2))) % 256;
            e.load = (b >= 128) ? 16'(b + 65280) : 16'(b);
        end else begin
            e.load = 16'(di);
        end
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0; opcode = op_br; addr = '0; wdata = '0;
        dmem_rdata = '0; dmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_load = '0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            dmem_resp = 1'b0;
        end
    endtask

    // Presents one op and plays the memory; records what the DUT drove.
    task automatic drive_op(input lc3b_opcode op, input logic [15:0] a, wd, rd0, rd1,
                            input int l0, l1, output obs_t o);
        int ph, wcnt;
        bit rec, fin;
        o.addr = '0; o.be = '0; o.rd = '0; o.wr = '0; o.wd = '0;
        o.proto_err = '0; o.done_cyc = -1; o.load = '0;
        ph = 0; wcnt = 0; rec = 0; fin = 0;
        for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
            @(negedge clk);
            dmem_resp = 1'b0;
            if (cyc == 0) begin
                req_valid = 1'b1; opcode = op; addr = a; wdata = wd;
            end
            #1;
            if (dmem_read && dmem_write) o.proto_err[0] = 1'b1;
            if (cyc == 0 && (dmem_read || dmem_write)) o.proto_err[1] = 1'b1;
            if (cyc == 0 && done) o.proto_err[2] = 1'b1;
            if (done) begin
                o.done_cyc = cyc;
                o.load     = load_data;
                if (stall || dmem_read || dmem_write) o.proto_err[4] = 1'b1;
                fin = 1;
            end else begin
                if (!stall) o.proto_err[3] = 1'b1;
                if (dmem_read || dmem_write) begin
                    if (ph > 1) begin
                        o.proto_err[5] = 1'b1;
                    end else if (!rec) begin
                        rec = 1;
                        o.addr[ph] = dmem_address; o.be[ph] = dmem_byte_enable;
                        o.rd[ph] = dmem_read; o.wr[ph] = dmem_write; o.wd[ph] = dmem_wdata;
                    end else if (o.addr[ph] !== dmem_address || o.be[ph] !== dmem_byte_enable ||
                                 o.rd[ph] !== dmem_read || o.wr[ph] !== dmem_write) begin
                        o.proto_err[5] = 1'b1;
                    end
                    wcnt++;
                    if (wcnt == ((ph == 0) ? l0 : l1)) begin
                        dmem_resp  = 1'b1;
                        dmem_rdata = (ph == 0) ? rd0 : rd1;
                        ph++; wcnt = 0; rec = 0;
                    end
                end
            end
        end
        o.n_phase = ph;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if ({stall, done, dmem_read, dmem_write} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes: got %b required 0000", {stall, done, dmem_read, dmem_write});
        end
        checks++;
        if (load_data !== 16'h0000) begin
            failures++; $display("FAIL reset_load_data: got %h required 0000", load_data);
        end
        checks++;
        if ({dmem_address, dmem_wdata, dmem_byte_enable} !== 34'h0) begin
            failures++;
            $display("FAIL reset_bus: got addr=%h wdata=%h be=%b required zeros",
                     dmem_address, dmem_wdata, dmem_byte_enable);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            failures++; $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE);
        end
        @(negedge clk);
        req_valid = 1'b1; opcode = op_add;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL reset_nonmem_stall: got %b required 0", stall);
        end
    endtask

    task automatic test_directed();
        dir_t tab[6];
        obs_t o;
        int   fp;
        tab[0] = '{op_ldr, 16'h3005, 16'h0000, 16'hBEEF, 16'h0000, 2, 1, 1,
                   16'h0000, 16'h3004, 2'b11, 1'b0, 16'h0000, 16'hBEEF, 3};
        tab[1] = '{op_ldb, 16'h3001, 16'h0000, 16'h80FF, 16'h0000, 1, 1, 1,
                   16'h0000, 16'h3001, 2'b10, 1'b0, 16'h0000, 16'hFF80, 2};
        tab[2] = '{op_ldb, 16'h3000, 16'h0000, 16'h80FF, 16'h0000, 3, 1, 1,
                   16'h0000, 16'h3000, 2'b01, 1'b0, 16'h0000, 16'hFFFF, 4};
        tab[3] = '{op_stb, 16'h4003, 16'h12AB, 16'h0000, 16'h0000, 2, 1, 1,
                   16'h0000, 16'h4003, 2'b10, 1'b1, 16'hABAB, 16'hFFFF, 3};
        tab[4] = '{op_ldi, 16'h5000, 16'h0000, 16'h6002, 16'h0042, 2, 1, 2,
                   16'h5000, 16'h6002, 2'b11, 1'b0, 16'h0000, 16'h0042, 4};
        tab[5] = '{op_str, 16'h7001, 16'h5A5A, 16'h0000, 16'h0000, 1, 1, 1,
                   16'h0000, 16'h7000, 2'b11, 1'b1, 16'h5A5A, 16'h0042, 2};
        for (int i = 0; i < 6; i++) begin
            drive_op(tab[i].op, tab[i].a, tab[i].wd, tab[i].rd0, tab[i].rd1,
                     tab[i].l0, tab[i].l1, o);
            fp = tab[i].nph - 1;
            checks++;
            if (o.done_cyc != tab[i].done_cyc || o.n_phase != tab[i].nph) begin
                failures++;
                $display("FAIL dir%0d_timing: got done_cyc=%0d phases=%0d required done_cyc=%0d phases=%0d",
                         i, o.done_cyc, o.n_phase, tab[i].done_cyc, tab[i].nph);
            end
            if (tab[i].nph == 2) begin
                checks++;
                if (o.addr[0] !== tab[i].ptr_addr || o.be[0] !== 2'b11 || o.rd[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL dir%0d_ptr: got addr=%h be=%b rd=%b required addr=%h be=11 rd=1",
                             i, o.addr[0], o.be[0], o.rd[0], tab[i].ptr_addr);
                end
            end
            checks++;
            if (o.addr[fp] !== tab[i].acc_addr || o.be[fp] !== tab[i].be ||
                o.wr[fp] !== tab[i].wr || o.rd[fp] !== !tab[i].wr) begin
                failures++;
                $display("FAIL dir%0d_access: got addr=%h be=%b rd=%b wr=%b required addr=%h be=%b wr=%b",
                         i, o.addr[fp], o.be[fp], o.rd[fp], o.wr[fp], tab[i].acc_addr, tab[i].be, tab[i].wr);
            end
            if (tab[i].wr) begin
                checks++;
                if (o.wd[fp] !== tab[i].wdat) begin
                    failures++;
                    $display("FAIL dir%0d_wdata: got %h required %h", i, o.wd[fp], tab[i].wdat);
                end
            end
            checks++;
            if (o.load !== tab[i].load) begin
                failures++; $display("FAIL dir%0d_load: got %h required %h", i, o.load, tab[i].load);
            end
            checks++;
            if (o.proto_err !== 6'b0) begin
                failures++; $display("FAIL dir%0d_protocol: got flags=%b required 000000", i, o.proto_err);
            end
        end
        model_load = tab[5].load;
    endtask

    task automatic test_non_mem();
        lc3b_opcode op;
        for (int i = 0; i < 12; i++) begin
            do op = lc3b_opcode'($urandom_range(0, 15)); while (tb_is_mem(op));
            @(negedge clk);
            req_valid  = ($urandom_range(0, 3) != 0);
            opcode     = op;
            addr       = 16'($urandom);
            dmem_resp  = (i % 3 == 1);
            dmem_rdata = 16'($urandom);
            #1;
            checks++;
            if ({stall, done, dmem_read, dmem_write} !== 4'b0000 || dbg_state !== IDLE) begin
                failures++;
                $display("FAIL nonmem%0d: got stall=%b done=%b rd=%b wr=%b state=%0d required all 0, IDLE",
                         i, stall, done, dmem_read, dmem_write, dbg_state);
            end
        end
        idle_cycles(1);
    endtask

    task automatic test_reset_mid();
        obs_t o, e;
        logic [15:0] exp_v;
        @(negedge clk);
        req_valid = 1'b1; opcode = op_sti; addr = 16'h8001; wdata = 16'h1234; dmem_resp = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++; $display("FAIL rstmid_accept_stall: got %b required 1", stall);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dmem_read !== 1'b1 || dmem_address !== 16'h8000 || dbg_state !== PTR) begin
            failures++;
            $display("FAIL rstmid_ptr: got rd=%b addr=%h state=%0d required rd=1 addr=8000 PTR",
                     dmem_read, dmem_address, dbg_state);
        end
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (dmem_read !== 1'b0 || dmem_write !== 1'b0 || dbg_state !== IDLE || load_data !== 16'h0) begin
            failures++;
            $display("FAIL rstmid_after: got rd=%b wr=%b state=%0d load=%h required 0 0 IDLE 0000",
                     dmem_read, dmem_write, dbg_state, load_data);
        end
        dmem_resp = 1'b1; dmem_rdata = 16'hFFFF;
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        checks++;
        if (dbg_state !== IDLE || done !== 1'b0 || dmem_read !== 1'b0 || dmem_write !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_late_resp: got state=%0d done=%b rd=%b wr=%b required IDLE 0 0 0",
                     dbg_state, done, dmem_read, dmem_write);
        end
        model_load = '0;
        e = model_op(op_ldr, 16'h2222, 16'h0, 16'hC0DE, 16'h0, 2, 1, model_load);
        exp_q.push_back(e.load);
        model_load = e.load;
        drive_op(op_ldr, 16'h2222, 16'h0, 16'hC0DE, 16'h0, 2, 1, o);
        exp_v = exp_q.pop_front();
        checks++;
        if (o.load !== exp_v || o.done_cyc != e.done_cyc || o.proto_err !== 6'b0) begin
            failures++;
            $display("FAIL rstmid_ldr: got load=%h done_cyc=%0d flags=%b required load=%h done_cyc=%0d flags=0",
                     o.load, o.done_cyc, o.proto_err, exp_v, e.done_cyc);
        end
    endtask

    task automatic test_random_back_to_back();
        lc3b_opcode  ops[6];
        lc3b_opcode  op;
        logic [15:0] a, wd, rd0, rd1, exp_v;
        int          l0, l1, fp;
        obs_t        o, e;
        ops = '{op_ldr, op_ldb, op_ldi, op_str, op_stb, op_sti};
        for (int i = 0; i < 40; i++) begin
            op  = ops[$urandom_range(0, 5)];
            a   = 16'($urandom); wd = 16'($urandom);
            rd0 = 16'($urandom); rd1 = 16'($urandom);
            l0  = $urandom_range(1, 4); l1 = $urandom_range(1, 4);
            e = model_op(op, a, wd, rd0, rd1, l0, l1, model_load);
            exp_q.push_back(e.load);
            model_load = e.load;
            drive_op(op, a, wd, rd0, rd1, l0, l1, o);
            fp = e.n_phase - 1;
            checks++;
            if (o.done_cyc != e.done_cyc || o.n_phase != e.n_phase) begin
                failures++;
                $display("FAIL rand%0d_timing op=%0d: got done_cyc=%0d phases=%0d required done_cyc=%0d phases=%0d",
                         i, op, o.done_cyc, o.n_phase, e.done_cyc, e.n_phase);
            end
            for (int p = 0; p < e.n_phase; p++) begin
                checks++;
                if (o.addr[p] !== e.addr[p] || o.be[p] !== e.be[p] ||
                    o.rd[p] !== e.rd[p] || o.wr[p] !== e.wr[p]) begin
                    failures++;
                    $display("FAIL rand%0d_phase%0d op=%0d: got addr=%h be=%b rd=%b wr=%b required addr=%h be=%b rd=%b wr=%b",
                             i, p, op, o.addr[p], o.be[p], o.rd[p], o.wr[p],
                             e.addr[p], e.be[p], e.rd[p], e.wr[p]);
                end
            end
            if (e.wr[fp]) begin
                checks++;
                if (o.wd[fp] !== e.wd[fp]) begin
                    failures++;
                    $display("FAIL rand%0d_wdata op=%0d: got %h required %h", i, op, o.wd[fp], e.wd[fp]);
                end
            end
            exp_v = exp_q.pop_front();
            checks++;
            if (o.load !== exp_v) begin
                failures++; $display("FAIL rand%0d_load op=%0d: got %h required %h", i, op, o.load, exp_v);
            end
            checks++;
            if (o.proto_err !== 6'b0) begin
                failures++; $display("FAIL rand%0d_protocol: got flags=%b required 000000", i, o.proto_err);
            end
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        do_reset();
        test_reset();
        test_directed();
        test_non_mem();
        test_reset_mid();
        test_random_back_to_back();
        idle_cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
